// File: rtl/neopix_pkg.sv
// Shared WS2812 link definitions: nominal bit timing, ns-to-cycle conversion and decoder FSM states.
package neopix_pkg;

    localparam int unsigned T0H_NS    = 400;
    localparam int unsigned T1H_NS    = 800;
    localparam int unsigned TBIT_NS   = 1250;
    localparam int unsigned TLATCH_NS = 50_000;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Rounds up so that a threshold is never shorter than the requested time.
    function automatic int unsigned ns_to_cycles(input longint unsigned ns,
                                                 input longint unsigned clk_hz);
        longint unsigned cyc;
        cyc = (ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        return cyc[31:0];
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input, clears to 0 on reset.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d_async;
            q    <= meta;
        end
    end

endmodule

// File: rtl/neopix_decoder.sv
// WS2812 receiver: measures synchronized high/low widths, decodes GRB words MSB-first,
// and flags frame latch gaps and pulse-width errors.
//
//  state | meaning
//  SYNC  | waiting for a full latch-length low before trusting the line
//  LOW   | between bits; a long enough low here ends the frame
//  HIGH  | measuring a bit's high pulse
module neopix_decoder
    import neopix_pkg::*;
#(
    parameter int unsigned CLK_RATE_HZ = 50_000_000,
    parameter int unsigned T_THRESH_NS = 600,
    parameter int unsigned T_MIN_NS    = 150,
    parameter int unsigned T_MAX_NS    = 1500,
    parameter int unsigned T_LATCH_NS  = 50_000,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_neopix,
    output logic [23:0]      o_pixel,
    output logic             o_pixel_valid,
    output logic [IDX_W-1:0] o_pixel_idx,
    output logic             o_latch,
    output logic             o_partial,
    output logic             o_err
);

    localparam int unsigned THRESH = ns_to_cycles(T_THRESH_NS, CLK_RATE_HZ);
    localparam int unsigned MIN_W  = ns_to_cycles(T_MIN_NS, CLK_RATE_HZ);
    localparam int unsigned MAX_W  = ns_to_cycles(T_MAX_NS, CLK_RATE_HZ);
    localparam int unsigned LATCH  = ns_to_cycles(T_LATCH_NS, CLK_RATE_HZ);
    localparam int unsigned CNT_W  = $clog2(LATCH + 1);

    localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] C_LATCH  = CNT_W'(LATCH);
    localparam logic [CNT_W-1:0] C_LATCH1 = CNT_W'(LATCH - 1);

    logic             line_s;
    logic             line_d;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    logic [22:0]      shift;
    logic [4:0]       bit_cnt;
    logic [IDX_W-1:0] idx;
    logic             rise;
    logic             fall;
    logic             bit_val;

    bit_sync u_sync (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .d_async (i_neopix),
        .q       (line_s)
    );

    assign rise    = line_s & ~line_d;
    assign fall    = ~line_s & line_d;
    assign bit_val = (cnt >= C_THRESH);

    // cnt holds how many cycles line_s has sat at its current level; on an edge cycle
    // it still holds the width of the level just ended.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            line_d        <= 1'b0;
            cnt           <= '0;
            state         <= SYNC;
            shift         <= '0;
            bit_cnt       <= '0;
            idx           <= '0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
            o_pixel_idx   <= '0;
            o_latch       <= 1'b0;
            o_partial     <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            line_d        <= line_s;
            o_pixel_valid <= 1'b0;
            o_latch       <= 1'b0;
            o_partial     <= 1'b0;
            o_err         <= 1'b0;

            if (line_s != line_d)
                cnt <= CNT_W'(1);
            else if (cnt != C_LATCH)
                cnt <= cnt + CNT_W'(1);

            unique case (state)
                SYNC: begin
                    if (!line_s && cnt == C_LATCH)
                        state <= LOW;
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (!line_s && !line_d && cnt == C_LATCH1) begin
                        if (bit_cnt != '0 || idx != '0) begin
                            o_latch   <= 1'b1;
                            o_partial <= (bit_cnt != '0);
                        end
                        bit_cnt <= '0;
                        idx     <= '0;
                    end
                end
                HIGH: begin
                    if (cnt > C_MAX || (fall && cnt < C_MIN)) begin
                        o_err   <= 1'b1;
                        state   <= SYNC;
                        bit_cnt <= '0;
                        idx     <= '0;
                    end else if (fall) begin
                        state <= LOW;
                        shift <= {shift[21:0], bit_val};
                        if (bit_cnt == 5'd23) begin
                            o_pixel       <= {shift, bit_val};
                            o_pixel_valid <= 1'b1;
                            o_pixel_idx   <= idx;
                            bit_cnt       <= '0;
                            if (idx != '1)
                                idx <= idx + IDX_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule
